power_pipe: RTL and testbench
=============================

Name: power_pipe

Overview:
- Parametrised, pipelined successor to the fixed 7-bit cube core.
- Computes x^2 or x^3 per transaction, selected by a per-input mode bit.
- Operand width and signedness are parameters.
- Full valid/ready handshake on input and output, with backpressure; a sideband tag travels with each operand.
- Sits in the optics datapath feeding the Snell-law polynomial/series evaluator.

Parameters:
- W, 7, operand width in bits (2..16).
- SIGNED, 0, 0 = unsigned operand; 1 = two's-complement operand.
- TAG_W, 4, width of sideband tag carried alongside each operand.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand presented.
- in_ready  out  1  block accepts operand this cycle.
- x  in  W  operand.
- mode  in  1  0 = square, 1 = cube.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result presented.
- out_ready  in  1  downstream accepts result.
- y  out  3W  result.
- out_tag  out  TAG_W  tag of the result.
- out_mode  out  1  mode of the result.

Behaviour:
- Reset: rst_n sampled low at a clk edge clears both stage valid flags; out_valid=0, y=0, out_tag=0, out_mode=0 on the following cycle. Reset mid-operation discards all in-flight data; no partial result is emitted afterwards.
- Pipeline stage S1 (registered):
  - Captures x, mode, tag.
  - Computes sq = x*x, 2W bits. Signed multiply when SIGNED=1, so sq is always non-negative.
- Pipeline stage S2 (registered, drives outputs):
  - mode=1: y = sq*x, 3W bits. Signed product when SIGNED=1.
  - mode=0: y = sq zero-extended to 3W.
- Width: 3W holds all results exactly. No overflow and no saturation.
- Handshake:
  - Input transfer occurs on a cycle with in_valid & in_ready. Output transfer occurs on a cycle with out_valid & out_ready.
  - s2_adv = !s2_valid | out_ready; s1_adv = !s1_valid | s2_adv; in_ready = s1_adv.
  - in_ready is combinational from out_ready and the stage valids. It is not registered.
  - S1 loads when s1_adv; s1_valid <= in_valid.
  - S2 loads when s2_adv; s2_valid <= s1_valid.
- Latency: exactly 2 cycles from input transfer to out_valid when unstalled. Throughput 1 per cycle.
- Stall: while out_valid=1 and out_ready=0, y, out_tag and out_mode hold stable. S1 holds if occupied. in_ready=0 only when both stages are full and out_ready=0.
- Simultaneous accept and emit: when both stages are full and out_ready=1, the block accepts a new input the same cycle. No bubble is inserted.
- Ordering: strictly FIFO. No reordering and no drops.
- Empty: with in_valid=0, results drain; out_valid falls the cycle after the last transfer.
- x, mode and in_tag are ignored when in_valid=0. Stage data registers are don't-care while invalid, except that the outputs reset to 0.

Test Plan:
1. W=7, SIGNED=0, x=3, mode=1, out_ready=1 -> two cycles after accept: y=27, out_valid high for 1 cycle, out_tag echoes in_tag.
2. Back-to-back unsigned stream x=127 mode=1, x=127 mode=0, x=0 mode=1 -> consecutive outputs 2048383, 16129, 0, one per cycle, tags in order.
3. SIGNED=1, W=7: x=7'h7D (-3) mode=1 -> y=21'h1FFFE5. x=7'h40 (-64) mode=0 -> 4096. x=7'h40 mode=1 -> 21'h1C0000.
4. Backpressure: stream 5 operands, hold out_ready=0 for 4 cycles mid-stream.
   - in_ready drops once 2 results are buffered.
   - y stays stable while held.
   - All 5 results are delivered in order; no loss or duplication.
5. Reset mid-flight: accept 2 operands, assert rst_n=0 for 1 cycle before any output -> out_valid=0 and y=0 next cycle; no stale result ever appears. in_ready=1 after release.
6. Random stress: W=5, SIGNED=1, random in_valid/out_ready -> scoreboard matches the reference model exactly, including the boundary operands -16 and 15.

Source files
------------

// File: rtl/power_pipe.sv
// power_pipe: two-stage pipelined x^2 / x^3 engine with valid/ready flow control.
//
// Stage S1 registers the operand, mode and tag together with the square x*x.
// Stage S2 registers the final result (x^3 = sq*x, or sq zero-extended) and
// drives the output port directly, so every output is a flop.
// The 3W-bit result holds every possible value exactly, so nothing overflows
// or saturates.
//
// Parameters:
//   W      operand width in bits (2..16)
//   SIGNED 0 = unsigned operand, 1 = two's-complement operand
//   TAG_W  width of the sideband tag that travels with each operand
//
// Ports:
//   clk, rst_n           rising-edge clock, synchronous active-low reset
//   in_valid / in_ready  input handshake (in_ready is combinational)
//   x, mode, in_tag      operand, 0 = square / 1 = cube, sideband tag
//   out_valid/out_ready  output handshake
//   y, out_tag, out_mode result, tag and mode of the presented result
module power_pipe #(
    parameter int W      = 7,
    parameter int SIGNED = 0,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      x,
    input  logic              mode,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3*W-1:0]    y,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_mode
);

    localparam int YW = 3 * W;

    // Stage S1 state
    logic              s1_valid_r;
    logic [W-1:0]      s1_x_r;
    logic [2*W-1:0]    s1_sq_r;
    logic              s1_mode_r;
    logic [TAG_W-1:0]  s1_tag_r;

    // Stage S2 state (drives the outputs)
    logic              s2_valid_r;
    logic [YW-1:0]     y_r;
    logic [TAG_W-1:0]  tag_r;
    logic              mode_r;

    // Combinational helpers
    logic              s1_adv_s;
    logic              s2_adv_s;
    logic [2*W-1:0]    xe_sq_s;
    logic [YW-1:0]     xe_cu_s;
    logic [2*W-1:0]    sq_s;
    logic [YW-1:0]     cube_s;

    // Advance conditions: a stage may load when it is empty or its successor moves.
    always_comb begin
        s2_adv_s = ~s2_valid_r | out_ready;
        s1_adv_s = ~s1_valid_r | s2_adv_s;
    end

    assign in_ready = s1_adv_s;

    // Arithmetic. Operands are extended to the product width (sign or zero
    // according to SIGNED) and multiplied as plain bit vectors: the low bits of
    // the product equal the two's-complement result, and because the exact
    // square fits in 2W bits and the exact cube fits in 3W bits, no information
    // is lost. The square is never negative, so it is always zero-extended.
    always_comb begin
        xe_sq_s = {{W{1'b0}}, x};
        xe_cu_s = {{(2*W){1'b0}}, s1_x_r};
        if (SIGNED != 0) begin
            xe_sq_s = {{W{x[W-1]}}, x};
            xe_cu_s = {{(2*W){s1_x_r[W-1]}}, s1_x_r};
        end else begin
            xe_sq_s = {{W{1'b0}}, x};
            xe_cu_s = {{(2*W){1'b0}}, s1_x_r};
        end
        sq_s   = xe_sq_s * xe_sq_s;
        cube_s = {{W{1'b0}}, s1_sq_r} * xe_cu_s;
    end

    // Stage S1 register: captures operand, mode, tag and the square.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_x_r     <= '0;
            s1_sq_r    <= '0;
            s1_mode_r  <= 1'b0;
            s1_tag_r   <= '0;
        end else if (s1_adv_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_x_r    <= x;
                s1_sq_r   <= sq_s;
                s1_mode_r <= mode;
                s1_tag_r  <= in_tag;
            end
        end
    end

    // Stage S2 register: forms the final result; holds while the sink stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            y_r        <= '0;
            tag_r      <= '0;
            mode_r     <= 1'b0;
        end else if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                y_r    <= s1_mode_r ? cube_s : {{W{1'b0}}, s1_sq_r};
                tag_r  <= s1_tag_r;
                mode_r <= s1_mode_r;
            end
        end
    end

    assign out_valid = s2_valid_r;
    assign y         = y_r;
    assign out_tag   = tag_r;
    assign out_mode  = mode_r;

endmodule

// File: tb/tb_power_pipe.sv
// Testbench for power_pipe. Three instances run in lockstep on the same
// handshake stream: W=7 unsigned, W=7 signed, and W=5 signed (which sees the
// low 5 bits of the shared operand). The reference model is a queue of
// in-flight transactions whose results are computed with plain integer
// arithmetic; a transaction becomes visible at the output one clock edge
// after it was accepted, and at most two transactions can be in flight.
module tb_power_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        mode;
    logic        out_ready;
    logic [6:0]  x;
    logic [3:0]  in_tag;

    logic        ir_u7, ir_s7, ir_s5;
    logic        ov_u7, ov_s7, ov_s5;
    logic [20:0] y_u7, y_s7;
    logic [14:0] y_s5;
    logic [3:0]  tag_u7, tag_s7, tag_s5;
    logic        om_u7, om_s7, om_s5;

    always #5 clk = ~clk;

    power_pipe #(.W(7), .SIGNED(0), .TAG_W(4)) u_u7 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_u7),
        .x(x), .mode(mode), .in_tag(in_tag), .out_valid(ov_u7),
        .out_ready(out_ready), .y(y_u7), .out_tag(tag_u7), .out_mode(om_u7));

    power_pipe #(.W(7), .SIGNED(1), .TAG_W(4)) u_s7 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_s7),
        .x(x), .mode(mode), .in_tag(in_tag), .out_valid(ov_s7),
        .out_ready(out_ready), .y(y_s7), .out_tag(tag_s7), .out_mode(om_s7));

    power_pipe #(.W(5), .SIGNED(1), .TAG_W(4)) u_s5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_s5),
        .x(x[4:0]), .mode(mode), .in_tag(in_tag), .out_valid(ov_s5),
        .out_ready(out_ready), .y(y_s5), .out_tag(tag_s5), .out_mode(om_s5));

    typedef struct {
        longint   yu7;
        longint   ys7;
        longint   ys5;
        logic [3:0] tag;
        logic     md;
        int       acc;
    } item_t;

    item_t q[$];
    int errors    = 0;
    int checks    = 0;
    int edge_cnt  = 0;
    int dut_emits = 0;

    // x^2 or x^3 of the low w bits of xv, reduced to 3w bits.
    function automatic longint ref_pow(input logic [6:0] xv, input logic md,
                                       input bit sgn, input int w);
        longint v;
        longint r;
        v = longint'(xv) & ((64'sd1 <<< w) - 64'sd1);
        if (sgn && v >= (64'sd1 <<< (w - 1))) v = v - (64'sd1 <<< w);
        r = md ? v * v * v : v * v;
        return r & ((64'sd1 <<< (3 * w)) - 64'sd1);
    endfunction

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    function automatic bit model_ov();
        return (q.size() > 0) && (q[0].acc < edge_cnt);
    endfunction

    task automatic check_out();
        bit eov;
        eov = model_ov();
        chk("out_valid", {61'd0, ov_u7, ov_s7, ov_s5}, {61'd0, eov, eov, eov});
        if (eov) begin
            chk("y_u7", {43'd0, y_u7}, q[0].yu7);
            chk("y_s7", {43'd0, y_s7}, q[0].ys7);
            chk("y_s5", {49'd0, y_s5}, q[0].ys5);
            chk("out_tag", {52'd0, tag_u7, tag_s7, tag_s5},
                {52'd0, q[0].tag, q[0].tag, q[0].tag});
            chk("out_mode", {61'd0, om_u7, om_s7, om_s5},
                {61'd0, q[0].md, q[0].md, q[0].md});
        end
    endtask

    // One clock: check in_ready, advance the model across the edge, check outputs.
    task automatic cycle(output bit acc);
        bit eir;
        bit emit;
        item_t it;
        #1;
        eir  = !((q.size() == 2) && !out_ready);
        chk("in_ready", {61'd0, ir_u7, ir_s7, ir_s5}, {61'd0, eir, eir, eir});
        acc  = in_valid && eir && rst_n;
        emit = model_ov() && out_ready;
        dut_emits += (ov_u7 && out_ready && rst_n) ? 1 : 0;
        it.yu7 = ref_pow(x, mode, 1'b0, 7);
        it.ys7 = ref_pow(x, mode, 1'b1, 7);
        it.ys5 = ref_pow(x, mode, 1'b1, 5);
        it.tag = in_tag;
        it.md  = mode;
        @(posedge clk);
        edge_cnt++;
        if (!rst_n) begin
            q.delete();
        end else begin
            if (emit) void'(q.pop_front());
            if (acc) begin
                it.acc = edge_cnt;
                q.push_back(it);
            end
        end
        @(negedge clk);
        check_out();
    endtask

    task automatic drive(input logic v, input logic [6:0] xv, input logic md, input logic [3:0] tg);
        in_valid = v;
        x        = xv;
        mode     = md;
        in_tag   = tg;
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_ov"}, {61'd0, ov_u7, ov_s7, ov_s5}, 64'd0);
        chk({nm, "_y"}, {7'd0, y_u7, y_s7, y_s5}, 64'd0);
        chk({nm, "_tag"}, {52'd0, tag_u7, tag_s7, tag_s5}, 64'd0);
        chk({nm, "_mode"}, {61'd0, om_u7, om_s7, om_s5}, 64'd0);
    endtask

    logic [6:0] ops [5];

    initial begin
        bit a;
        int idx;
        rst_n = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 7'd0, 1'b0, 4'd0);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // 1: single unsigned cube, 3^3 = 27, visible two cycles after accept
        drive(1'b1, 7'd3, 1'b1, 4'hA);
        cycle(a);
        drive(1'b0, 7'd0, 1'b0, 4'h0);
        cycle(a);
        chk("t1_y", {43'd0, y_u7}, 64'd27);
        chk("t1_tag", {60'd0, tag_u7}, 64'hA);
        cycle(a);
        cycle(a);

        // 2: back-to-back unsigned stream
        drive(1'b1, 7'd127, 1'b1, 4'h1); cycle(a);
        drive(1'b1, 7'd127, 1'b0, 4'h2); cycle(a);
        chk("t2_y0", {43'd0, y_u7}, 64'd2048383);
        drive(1'b1, 7'd0, 1'b1, 4'h3);   cycle(a);
        chk("t2_y1", {43'd0, y_u7}, 64'd16129);
        drive(1'b0, 7'd0, 1'b0, 4'h0);   cycle(a);
        chk("t2_y2", {43'd0, y_u7}, 64'd0);
        repeat (2) cycle(a);

        // 3: signed W=7 corner values
        drive(1'b1, 7'h7D, 1'b1, 4'h4); cycle(a);
        drive(1'b1, 7'h40, 1'b0, 4'h5); cycle(a);
        chk("t3_neg3_cube", {43'd0, y_s7}, 64'h1FFFE5);
        drive(1'b1, 7'h40, 1'b1, 4'h6); cycle(a);
        chk("t3_neg64_sq", {43'd0, y_s7}, 64'd4096);
        drive(1'b0, 7'd0, 1'b0, 4'h0);  cycle(a);
        chk("t3_neg64_cube", {43'd0, y_s7}, 64'h1C0000);
        repeat (2) cycle(a);

        // 4: backpressure mid-stream
        ops[0] = 7'd5; ops[1] = 7'h7F; ops[2] = 7'd9; ops[3] = 7'h41; ops[4] = 7'd2;
        idx = 0;
        dut_emits = 0;
        for (int c = 0; c < 16; c++) begin
            out_ready = !(c >= 2 && c < 6);
            if (idx < 5) drive(1'b1, ops[idx], idx[0], 4'(idx + 8));
            else         drive(1'b0, 7'd0, 1'b0, 4'h0);
            cycle(a);
            if (a) idx++;
        end
        chk("t4_sent", 64'(idx), 64'd5);
        chk("t4_delivered", 64'(dut_emits), 64'd5);
        out_ready = 1'b1;

        // 5: reset mid-flight discards everything
        drive(1'b1, 7'd11, 1'b1, 4'hC); cycle(a);
        out_ready = 1'b0;
        drive(1'b1, 7'd12, 1'b1, 4'hD); cycle(a);
        drive(1'b0, 7'd0, 1'b0, 4'h0);
        rst_n = 1'b0;
        cycle(a);
        check_reset_outputs("t5");
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) cycle(a);

        // 6: random stress, including the 5-bit boundaries -16 and 15
        for (int c = 0; c < 400; c++) begin
            logic [6:0] xv;
            xv = 7'($urandom);
            if (c % 17 == 0) xv = 7'h10;
            if (c % 17 == 5) xv = 7'h0F;
            if (c % 23 == 3) xv = 7'h40;
            drive(($urandom % 4) != 0, xv, 1'($urandom), 4'($urandom));
            out_ready = ($urandom % 3) != 0;
            cycle(a);
        end
        drive(1'b0, 7'd0, 1'b0, 4'h0);
        out_ready = 1'b1;
        repeat (4) cycle(a);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
